// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer
//   Shares one external memory bus between the instruction-fetch port (IF)
//   and the load/store port (LS). IDLE arbitrates (round-robin on
//   contention), ACCESS holds the bus until mem_ready or timeout, RESP
//   returns a one-cycle done pulse (with err/rdata) to the granted port.
// Ports:
//   clk, rst                     clock, async active-high reset
//   if_req/if_addr               fetch request (always a read)
//   if_done/if_err/if_rdata      fetch completion
//   ls_req/ls_opcode/ls_addr/ls_wdata  load/store request (LDR=1101, STR=1110)
//   ls_done/ls_err/ls_rdata      load/store completion
//   mem_en/mem_rw/mem_addr/mem_dout/mem_din/mem_ready  memory bus
//   busy                         sequencer not idle
module mem_access_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic [3:0]        ls_opcode,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_done,
  output logic              ls_err,
  output logic              if_err,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dout,
  input  logic [DATA_W-1:0] mem_din,
  input  logic              mem_ready,
  output logic              busy
);

  localparam int          CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [3:0]  OP_LDR   = 4'b1101;
  localparam logic [3:0]  OP_STR   = 4'b1110;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                last_ls_q, last_ls_d;    // 1: LS was granted last
  logic                grant_ls_q, grant_ls_d;  // port owning the current transaction
  logic                mem_en_q, mem_en_d;
  logic                mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_dout_q, mem_dout_d;
  logic                if_done_q, if_done_d;
  logic                if_err_q, if_err_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic                ls_done_q, ls_done_d;
  logic                ls_err_q, ls_err_d;
  logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;
  logic                busy_q, busy_d;

  logic                pick_ls;
  logic                ls_legal;
  logic                fin, fin_err;
  logic [DATA_W-1:0]   fin_data;

  // LS wins when it is the only requester, or on contention when IF was last.
  assign pick_ls  = ls_req && (!if_req || !last_ls_q);
  assign ls_legal = (ls_opcode == OP_LDR) || (ls_opcode == OP_STR);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_ls_d  = last_ls_q;
    grant_ls_d = grant_ls_q;
    mem_en_d   = mem_en_q;
    mem_rw_d   = mem_rw_q;
    mem_addr_d = mem_addr_q;
    mem_dout_d = mem_dout_q;
    if_done_d  = 1'b0;
    if_err_d   = 1'b0;
    if_rdata_d = '0;
    ls_done_d  = 1'b0;
    ls_err_d   = 1'b0;
    ls_rdata_d = '0;
    busy_d     = busy_q;
    fin        = 1'b0;
    fin_err    = 1'b0;
    fin_data   = '0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (if_req || ls_req) begin
          busy_d     = 1'b1;
          grant_ls_d = pick_ls;
          if (pick_ls && !ls_legal) begin
            // Illegal opcode never touches the bus; answer straight away.
            state_d   = RESP;
            ls_done_d = 1'b1;
            ls_err_d  = 1'b1;
          end else begin
            state_d    = ACCESS;
            cnt_d      = '0;
            last_ls_d  = pick_ls;
            mem_en_d   = 1'b1;
            mem_rw_d   = !pick_ls || (ls_opcode == OP_LDR);
            mem_addr_d = pick_ls ? ls_addr : if_addr;
            mem_dout_d = (pick_ls && ls_opcode == OP_STR) ? ls_wdata : '0;
          end
        end
      end

      ACCESS: begin
        if (mem_ready) begin
          fin      = 1'b1;
          fin_data = mem_rw_q ? mem_din : '0;
        end else if (cnt_q == CNT_LAST) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end

        if (fin) begin
          state_d    = RESP;
          mem_en_d   = 1'b0;
          mem_rw_d   = 1'b0;
          mem_addr_d = '0;
          mem_dout_d = '0;
          if (grant_ls_q) begin
            ls_done_d  = 1'b1;
            ls_err_d   = fin_err;
            ls_rdata_d = fin_data;
          end else begin
            if_done_d  = 1'b1;
            if_err_d   = fin_err;
            if_rdata_d = fin_data;
          end
        end
      end

      RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_ls_q  <= 1'b1;
      grant_ls_q <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_rw_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_dout_q <= '0;
      if_done_q  <= 1'b0;
      if_err_q   <= 1'b0;
      if_rdata_q <= '0;
      ls_done_q  <= 1'b0;
      ls_err_q   <= 1'b0;
      ls_rdata_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_ls_q  <= last_ls_d;
      grant_ls_q <= grant_ls_d;
      mem_en_q   <= mem_en_d;
      mem_rw_q   <= mem_rw_d;
      mem_addr_q <= mem_addr_d;
      mem_dout_q <= mem_dout_d;
      if_done_q  <= if_done_d;
      if_err_q   <= if_err_d;
      if_rdata_q <= if_rdata_d;
      ls_done_q  <= ls_done_d;
      ls_err_q   <= ls_err_d;
      ls_rdata_q <= ls_rdata_d;
      busy_q     <= busy_d;
    end
  end

  assign if_done  = if_done_q;
  assign if_err   = if_err_q;
  assign if_rdata = if_rdata_q;
  assign ls_done  = ls_done_q;
  assign ls_err   = ls_err_q;
  assign ls_rdata = ls_rdata_q;
  assign mem_en   = mem_en_q;
  assign mem_rw   = mem_rw_q;
  assign mem_addr = mem_addr_q;
  assign mem_dout = mem_dout_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
module tb_mem_access_sequencer;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, ls_req;
  logic [31:0] if_addr, ls_addr, ls_wdata, mem_din;
  logic [3:0]  ls_opcode;
  logic        mem_ready;
  logic        if_done, if_err, ls_done, ls_err, mem_en, mem_rw, busy;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_dout;

  int total = 0;
  int bad   = 0;

  mem_access_sequencer #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_opcode(ls_opcode), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_done(ls_done), .ls_err(ls_err), .if_err(if_err), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_din(mem_din), .mem_ready(mem_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_if;
    logic [3:0]  op;
    logic [31:0] addr, wdata, din;
    int          delay;      // mem_ready=0 cycles before ready; >= TO never ready
    int          exp_en, exp_lat;
    bit          exp_err;
    logic [31:0] exp_rdata;
    bit          exp_rw;
    logic [31:0] exp_dout;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {32'(if_done | if_err | ls_done | ls_err | mem_en | mem_rw | busy),
            if_rdata | ls_rdata | mem_addr | mem_dout};
  endfunction

  // Reference: outcome of one isolated transaction from the protocol rules.
  task automatic model(input bit is_if, input logic [3:0] op, input logic [31:0] wdata,
                       input logic [31:0] din, input int delay,
                       output int en, output int lat, output bit err,
                       output logic [31:0] rdata, output bit rw, output logic [31:0] dout);
    bit legal, rd;
    legal = is_if || op == 4'b1101 || op == 4'b1110;
    rd    = is_if || op == 4'b1101;
    rw    = rd;
    dout  = rd ? 32'h0 : wdata;
    if (!legal) begin
      en = 0; lat = 1; err = 1; rdata = 0;
    end else if (delay < TO) begin
      en = delay + 1; lat = delay + 2; err = 0; rdata = rd ? din : 32'h0;
    end else begin
      en = TO; lat = TO + 1; err = 1; rdata = 0;
    end
  endtask

  task automatic run_txn(input string nm, input bit is_if, input logic [3:0] op,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] din, input int delay,
                         input int exp_en, input int exp_lat, input bit exp_err,
                         input logic [31:0] exp_rdata, input bit exp_rw,
                         input logic [31:0] exp_dout, input bit rel_rst);
    int en_cnt = 0, lat = 0, busy_cnt = 0, other = 0, mis = 0;
    bit seen = 0;
    logic err_o = 0;
    logic [31:0] rdata_o = 0;
    @(negedge clk);
    if (rel_rst) rst = 1'b0;
    if (is_if) begin
      if_req = 1; if_addr = addr; ls_opcode = 4'($urandom);
    end else begin
      ls_req = 1; ls_opcode = op; ls_addr = addr; ls_wdata = wdata;
    end
    mem_ready = 0; mem_din = $urandom;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (is_if ? ls_done : if_done) other++;
      if (mem_en) begin
        en_cnt++;
        if (mem_rw !== exp_rw || mem_addr !== addr || mem_dout !== exp_dout) mis++;
      end
      if (is_if ? if_done : ls_done) begin
        seen = 1; lat = c;
        err_o   = is_if ? if_err : ls_err;
        rdata_o = is_if ? if_rdata : ls_rdata;
        if_req = 0; ls_req = 0; mem_ready = 0;
      end else begin
        mem_ready = mem_en && (en_cnt - 1 == delay);
        mem_din   = mem_ready ? din : $urandom;
      end
    end
    chk({nm, ".done_seen"}, 64'(seen), 64'd1);
    chk({nm, ".en_cycles"}, 64'(en_cnt), 64'(exp_en));
    chk({nm, ".latency"}, 64'(lat), 64'(exp_lat));
    chk({nm, ".err"}, 64'(err_o), 64'(exp_err));
    chk({nm, ".rdata"}, 64'(rdata_o), 64'(exp_rdata));
    chk({nm, ".other_done"}, 64'(other), 64'd0);
    chk({nm, ".bus_fields"}, 64'(mis), 64'd0);
    chk({nm, ".busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
    @(negedge clk);
    chk({nm, ".post_done"}, 64'(if_done | ls_done), 64'd0);
    chk({nm, ".post_rdata"}, 64'(if_rdata | ls_rdata), 64'd0);
    chk({nm, ".post_busy"}, 64'(busy), 64'd0);
  endtask

  vec_t vecs[8];

  initial begin
    rst = 1; if_req = 0; ls_req = 0; if_addr = 0; ls_addr = 0; ls_wdata = 0;
    ls_opcode = 0; mem_din = 0; mem_ready = 0;

    vecs[0] = '{0, 4'b1101, 32'h12345678, 32'h11111111, 32'h9abcdef0, 1,  2, 3,  0, 32'h9abcdef0, 1, 32'h0};
    vecs[1] = '{0, 4'b1110, 32'h00000010, 32'hdeadbeef, 32'h55555555, 0,  1, 2,  0, 32'h0,        0, 32'hdeadbeef};
    vecs[2] = '{0, 4'b0001, 32'h00000020, 32'h0,        32'h0,        0,  0, 1,  1, 32'h0,        0, 32'h0};
    vecs[3] = '{1, 4'b0000, 32'h00000400, 32'h0,        32'h77777777, 99, 15, 16, 1, 32'h0,       1, 32'h0};
    vecs[4] = '{1, 4'b0000, 32'h00000404, 32'h0,        32'hcafef00d, 3,  4, 5,  0, 32'hcafef00d, 1, 32'h0};
    vecs[5] = '{0, 4'b1101, 32'h00000800, 32'h0,        32'h13572468, 14, 15, 16, 0, 32'h13572468, 1, 32'h0};
    vecs[6] = '{0, 4'b1110, 32'h00000804, 32'ha5a5a5a5, 32'h0,        15, 15, 16, 1, 32'h0,       0, 32'ha5a5a5a5};
    vecs[7] = '{0, 4'b1111, 32'h00000808, 32'h0,        32'h0,        0,  0, 1,  1, 32'h0,        0, 32'h0};

    #2 chk("reset_outputs", all_outs(), 64'd0);
    @(negedge clk); @(negedge clk); rst = 0;

    // Contention from reset: IF first, then strict alternation, 3 cycles apart.
    begin
      int q[$]; int cyc[$]; int both = 0;
      @(negedge clk);
      if_req = 1; ls_req = 1; ls_opcode = 4'b1101;
      if_addr = 32'h0000a000; ls_addr = 32'h0000b000; mem_ready = 1; mem_din = $urandom;
      for (int c = 1; c <= 30 && q.size() < 4; c++) begin
        @(negedge clk);
        if (if_done && ls_done) both++;
        else if (if_done) begin q.push_back(0); cyc.push_back(c); end
        else if (ls_done) begin q.push_back(1); cyc.push_back(c); end
        mem_din = $urandom;
      end
      if_req = 0; ls_req = 0; mem_ready = 0;
      chk("rr.count", 64'(q.size()), 64'd4);
      chk("rr.both_done", 64'(both), 64'd0);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("rr.grant%0d", i), 64'(q.size() > i ? q[i] : 9), 64'(i % 2));
        chk($sformatf("rr.cycle%0d", i), 64'(cyc.size() > i ? cyc[i] : 0), 64'(2 + 3 * i));
      end
      @(negedge clk); @(negedge clk);
    end

    foreach (vecs[i])
      run_txn($sformatf("vec%0d", i), vecs[i].is_if, vecs[i].op, vecs[i].addr, vecs[i].wdata,
              vecs[i].din, vecs[i].delay, vecs[i].exp_en, vecs[i].exp_lat, vecs[i].exp_err,
              vecs[i].exp_rdata, vecs[i].exp_rw, vecs[i].exp_dout, 1'b0);

    // Reset during the 3rd ACCESS cycle of a stalled load.
    begin
      int en = 0; int dn = 0;
      @(negedge clk);
      ls_req = 1; ls_opcode = 4'b1101; ls_addr = 32'h00000777; mem_ready = 0;
      for (int c = 0; c < 10 && en < 3; c++) begin
        @(negedge clk);
        if (mem_en) en++;
        if (ls_done || if_done) dn++;
      end
      chk("rst.en_before", 64'(en), 64'd3);
      #1 rst = 1;
      #1 chk("rst.async_outputs", all_outs(), 64'd0);
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        if (ls_done || if_done) dn++;
      end
      chk("rst.no_done", 64'(dn), 64'd0);
      run_txn("rst_resume", 0, 4'b1110, 32'h00000888, 32'h0badf00d, 32'h0, 0,
              1, 2, 0, 32'h0, 0, 32'h0badf00d, 1'b1);
    end

    // Randomized isolated transactions against the reference.
    for (int n = 0; n < 40; n++) begin
      bit is_if; logic [3:0] op; logic [31:0] a, w, d; int dl, r;
      int en, lat; bit err, rw; logic [31:0] rdata, dout;
      is_if = 1'($urandom);
      r = $urandom_range(0, 3);
      op = (r < 2) ? 4'b1101 : (r == 2) ? 4'b1110 : 4'($urandom);
      a = $urandom; w = $urandom; d = $urandom;
      dl = $urandom_range(0, TO + 2);
      model(is_if, op, w, d, dl, en, lat, err, rdata, rw, dout);
      run_txn($sformatf("rnd%0d", n), is_if, op, a, w, d, dl, en, lat, err, rdata, rw, dout, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
Multi-cycle sequencer and arbiter that shares the single external memory bus between the instruction-fetch port and the load/store port.
- Decodes LDR (4'b1101) and STR (4'b1110) opcodes into bus read and write transactions, and runs fetches as reads.
- Holds the bus until the memory signals ready, aborting if the wait exceeds a timeout.
- Returns read data and completion/error pulses to the requester that was granted.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 15, maximum ACCESS cycles waiting for mem_ready before abort (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
if_req  in  1  fetch request; held until if_done
if_addr  in  ADDR_W  fetch address
if_done  out  1  one-cycle fetch completion pulse
if_rdata  out  DATA_W  fetched word; valid while if_done=1
ls_req  in  1  load/store request; held until ls_done
ls_opcode  in  4  1101=LDR, 1110=STR, any other value is illegal
ls_addr  in  ADDR_W  load/store address
ls_wdata  in  DATA_W  store data
ls_done  out  1  one-cycle load/store completion pulse
ls_err  out  1  with ls_done: illegal opcode or timeout
if_err  out  1  with if_done: timeout
ls_rdata  out  DATA_W  load data; valid while ls_done=1
mem_en  out  1  bus transaction active
mem_rw  out  1  1=read, 0=write
mem_addr  out  ADDR_W  bus address
mem_dout  out  DATA_W  write data to memory
mem_din  in  DATA_W  read data from memory
mem_ready  in  1  memory completes the current transaction this cycle
busy  out  1  state is not IDLE

Behaviour:
- Reset (async, immediate):
  - state=IDLE; every output=0.
  - wait counter=0; last_grant=LS, so the first contention goes to fetch.
  - Reset mid-ACCESS drops the transaction with no done pulse.
- States: IDLE, ACCESS, RESP. All outputs are registered.
- IDLE: sample requests every cycle.
  - Both if_req and ls_req high: grant the port not in last_grant (round-robin).
  - Only one request high: grant that port.
  - Granted LS with an illegal opcode: go to RESP with ls_err=1, and mem_en stays 0.
  - Otherwise, on the next edge:
    - latch addr, opcode and wdata;
    - set mem_en=1, mem_rw=(LDR or fetch), mem_addr, and mem_dout (STR only, else 0);
    - update last_grant; counter=0; go to ACCESS.
- ACCESS: mem_en, mem_rw, mem_addr and mem_dout hold stable.
  - mem_ready=1 sampled: capture mem_din for reads, drop mem_en, go to RESP with err=0.
  - mem_ready=0 and counter==TIMEOUT-1: drop mem_en, go to RESP with err=1 and rdata=0.
  - Else: counter+1.
  - Requests and inputs are ignored here; a requester dropping req mid-access does not cancel the transaction.
- RESP (exactly one cycle):
  - Granted port's done=1, plus its err and rdata; the other port's outputs stay 0.
  - Next state is IDLE.
  - rdata returns to 0 when done falls.
- Latency: request seen at edge k → mem_en high from cycle k+1.
  - mem_ready sampled at edge k+1 → done in cycle k+2, back to IDLE in cycle k+3.
  - Minimum: 3 cycles per transaction.
- Requester rule: deassert req, or present the next request, in the cycle after done. IDLE re-samples, so back-to-back requests from one port are legal.
- mem_ready while not in ACCESS is ignored.
- Counter width: clog2(TIMEOUT+1). mem_en is high for at most TIMEOUT cycles per transaction.
- busy=1 in ACCESS and RESP.

Test Plan:
1. LDR: ls_req=1, opcode=1101, addr=32'h12345678; mem_ready=1 with mem_din=32'h9abcdef0 on the 2nd mem_en cycle → mem_en/mem_rw=1 for 2 cycles, mem_addr=32'h12345678, then ls_done=1, ls_rdata=32'h9abcdef0, ls_err=0 for one cycle.
2. STR: opcode=1110, addr=32'h00000010, wdata=32'hdeadbeef; mem_ready on the 1st cycle → mem_en=1, mem_rw=0, mem_dout=32'hdeadbeef for 1 cycle; ls_done 2 cycles after the request edge; ls_rdata=0.
3. Illegal opcode 4'b0001 → mem_en never asserts; ls_done=1 and ls_err=1 one cycle after the request; busy=1 for exactly 1 cycle.
4. Contention: if_req and ls_req held high from reset, every mem_ready=1 → grants alternate IF, LS, IF, LS, with exactly one done pulse per transaction.
5. Timeout: TIMEOUT=15, mem_ready held 0 → mem_en high exactly 15 cycles, then if_done=1 with if_err=1 and if_rdata=0; the next request is served normally.
6. Async reset asserted in the 3rd ACCESS cycle → all outputs 0 before the next clock edge; no done pulse; after release a pending ls_req is serviced from IDLE.
